ff_excitation_driver: RTL and testbench
=======================================

Name: ff_excitation_driver

Overview:
- Drives the inputs of a single flip-flop under test (SR, JK, D or T, selected by a parameter) so that its state follows a serial stream of target bits. This makes it the excitation-side counterpart of the flip-flop models.
- Initialises the flip-flop through its active-low asynchronous clear/preset, checks the returned q against the expected sequence, and counts mismatches.
- Used in lab benches and FPGA demos, with the flip-flop clocked by the same ck.

Parameters:
- FF_TYPE, 0, flip-flop under test: 0=SR, 1=JK, 2=D, 3=T; other values illegal (simulation error at time 0).
- CW, 8, width of err_count.

Ports:
- ck  input  1  clock; the flip-flop under test shares this clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse in IDLE: begin a session.
- init_val  input  1  initial flip-flop state, sampled with start.
- stop  input  1  end the session: drain, then return to IDLE.
- in_valid  input  1  target bit available.
- in_data  input  1  target next state of the flip-flop.
- in_ready  output  1  accept target bit this cycle.
- x1  output  1  s / j / d / t, per FF_TYPE.
- x2  output  1  r / k; constant 0 for D and T.
- cl_n  output  1  async clear to the flip-flop, active low.
- pr_n  output  1  async preset to the flip-flop, active low.
- q  input  1  flip-flop state fed back.
- busy  output  1  high in any state other than IDLE.
- err  output  1  one-cycle pulse on mismatch.
- err_count  output  CW  saturating mismatch count for the session.
- done  output  1  one-cycle pulse on return to IDLE after stop.

Behaviour:
- Reset values: every output is registered. Reset gives state IDLE, x1=x2=0, cl_n=pr_n=1, in_ready=0, busy=0, err=0, err_count=0, done=0, tracked state cur=0, and both check-pipeline valids=0.
- Reset mid-session aborts immediately. No done pulse is produced and err_count is cleared.
- FSM states: IDLE -> INIT -> SETTLE -> RUN -> DRAIN -> IDLE.
- IDLE:
  - start=1 -> INIT. At that edge: cur<=init_val; cl_n<=init_val; pr_n<=~init_val (only one of them goes low); err_count<=0.
  - stop is ignored in IDLE.
- INIT: lasts one cycle. The async pin is released (cl_n=pr_n=1) at the next edge -> SETTLE.
- SETTLE: lasts one cycle, hold excitation -> RUN.
- RUN:
  - in_ready=1.
  - Accept = in_valid & in_ready at an edge. At the accept edge k: x1/x2 <= excitation(cur, in_data); cur<=in_data; exp1<=in_data; v1<=1.
  - Without an accept, x1/x2 <= hold excitation and v1<=0.
  - stop=1 -> DRAIN. If an accept occurs at the same edge, that bit is still accepted.
- Excitation for cur->next:
  - SR and JK: 0->0 gives 00; 0->1 gives 10; 1->0 gives 01; 1->1 gives 00. The SR 11 input is never driven (assertion in RTL).
  - D: x1=next.
  - T: x1=cur^next.
- Hold excitation (no accept): SR/JK 00; D x1=cur; T x1=0.
- Check pipeline:
  - Edge k+1: the flip-flop updates; exp2<=exp1, v2<=v1.
  - Edge k+2: if v2 and q!=exp2, then err<=1 and err_count<=err_count+1, saturating at 2^CW-1.
  - err is visible in the cycle after edge k+2. The pipeline runs every cycle, so back-to-back accepts give one check per cycle.
- DRAIN:
  - in_ready=0, hold excitation.
  - Stays 2 cycles so the last bit is checked, then goes to IDLE with done=1 for one cycle.
  - err_count holds its value until the next start or reset.
- start while busy is ignored.
- Open loop: cur tracks the expected value, never q. A mismatch does not resynchronise cur.

Test Plan:
- D type, reset, start init_val=0, stream 1,1,0,1,0 back-to-back -> cl_n low 1 cycle; x1 follows 1,1,0,1,0 from the accept edges; q equals each bit 2 edges after accept; err_count=0; done after stop+2 cycles.
- JK type, start init_val=1, stream 1,0,0,1 -> pr_n low 1 cycle, cl_n stays 1; (x1,x2)=00,01,00,10 on successive accepts; no err.
- T type, init 0, stream 1,0,1,1 with in_valid gaps of 2 cycles -> x1=1,1,1,0 on accept cycles and x1=0 in gap cycles; q matches; err_count=0.
- SR type with q forced to 0 by the bench, init 0, stream 1,1,1 -> 3 err pulses on consecutive cycles; err_count=3; with CW=2 and 5 forced mismatches, err_count saturates at 3.
- reset asserted in RUN with 2 bits in flight -> next cycle: IDLE, in_ready=0, err=0, err_count=0, no done; start ignored while busy; stop ignored in IDLE.
- stop on the same edge as an accept of bit 1 -> bit accepted and checked, DRAIN lasts 2 cycles, done pulses once.

Source files
------------

// File: rtl/ff_excitation_driver.sv
// ff_excitation_driver: steers a single SR/JK/D/T flip-flop through a serial
// stream of target states, initialises it via its async clear/preset, and
// checks the fed-back q two edges after each accepted bit.
module ff_excitation_driver #(
    parameter int FF_TYPE = 0,   // 0=SR, 1=JK, 2=D, 3=T
    parameter int CW      = 8    // width of err_count_o
) (
    input  logic          ck_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          init_val_i,
    input  logic          stop_i,
    input  logic          in_valid_i,
    input  logic          in_data_i,
    output logic          in_ready_o,
    output logic          x1_o,
    output logic          x2_o,
    output logic          cl_n_o,
    output logic          pr_n_o,
    input  logic          q_i,
    output logic          busy_o,
    output logic          err_o,
    output logic [CW-1:0] err_count_o,
    output logic          done_o
);

    if (FF_TYPE < 0 || FF_TYPE > 3) begin : g_bad_type
        $error("ff_excitation_driver: illegal FF_TYPE %0d", FF_TYPE);
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SETTLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic          cur_q, cur_d;
    logic          x1_q, x1_d;
    logic          x2_q, x2_d;
    logic          cl_n_q, cl_n_d;
    logic          pr_n_q, pr_n_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [CW-1:0] err_count_q, err_count_d;
    logic          done_q, done_d;
    logic          drain_cnt_q, drain_cnt_d;
    logic          exp1_q, exp1_d;
    logic          v1_q, v1_d;
    logic          exp2_q, exp2_d;
    logic          v2_q, v2_d;
    logic          accept;
    logic          cnt_clr;

    // Inputs that move the flip-flop from cur to nxt; {x1, x2}.
    function automatic logic [1:0] excite(input logic cur, input logic nxt);
        logic [1:0] x;
        x = 2'b00;
        case (FF_TYPE)
            0, 1:    x = {~cur & nxt, cur & ~nxt};
            2:       x = {nxt, 1'b0};
            default: x = {cur ^ nxt, 1'b0};
        endcase
        return x;
    endfunction

    // Inputs that keep the flip-flop at cur; {x1, x2}.
    function automatic logic [1:0] hold_exc(input logic cur);
        logic [1:0] x;
        x = 2'b00;
        if (FF_TYPE == 2) begin
            x = {cur, 1'b0};
        end
        return x;
    endfunction

    assign accept = in_valid_i & in_ready_q;

    // Session sequencing, excitation selection and the two-stage q check.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cl_n_d      = 1'b1;
        pr_n_d      = 1'b1;
        drain_cnt_d = 1'b0;
        done_d      = 1'b0;
        cnt_clr     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_INIT;
                    cur_d   = init_val_i;
                    cl_n_d  = init_val_i;
                    pr_n_d  = ~init_val_i;
                    cnt_clr = 1'b1;
                end
            end
            S_INIT:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_RUN;
            S_RUN: begin
                if (accept) begin
                    cur_d = in_data_i;
                end
                if (stop_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_cnt_d = 1'b1;
                if (drain_cnt_q) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    drain_cnt_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Open loop: excitation is always derived from the tracked state.
        if (accept) begin
            {x1_d, x2_d} = excite(cur_q, in_data_i);
        end else begin
            {x1_d, x2_d} = hold_exc(cur_d);
        end

        in_ready_d = (state_d == S_RUN);
        busy_d     = (state_d != S_IDLE);

        exp1_d = accept ? in_data_i : exp1_q;
        v1_d   = accept;
        exp2_d = exp1_q;
        v2_d   = v1_q;
        err_d  = v2_q & (q_i ^ exp2_q);

        err_count_d = err_count_q;
        if (cnt_clr) begin
            err_count_d = '0;
        end else if (err_d && (err_count_q != {CW{1'b1}})) begin
            err_count_d = err_count_q + CW'(1);
        end
    end

    // State and registered outputs; reset aborts any session in flight.
    always_ff @(posedge ck_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cur_q       <= 1'b0;
            x1_q        <= 1'b0;
            x2_q        <= 1'b0;
            cl_n_q      <= 1'b1;
            pr_n_q      <= 1'b1;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            done_q      <= 1'b0;
            drain_cnt_q <= 1'b0;
            exp1_q      <= 1'b0;
            v1_q        <= 1'b0;
            exp2_q      <= 1'b0;
            v2_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            cl_n_q      <= cl_n_d;
            pr_n_q      <= pr_n_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            done_q      <= done_d;
            drain_cnt_q <= drain_cnt_d;
            exp1_q      <= exp1_d;
            v1_q        <= v1_d;
            exp2_q      <= exp2_d;
            v2_q        <= v2_d;
        end
    end

    // The SR flip-flop must never see S and R asserted together.
    always_ff @(posedge ck_i) begin
        if (!reset_i && FF_TYPE == 0) begin
            assert (!(x1_q && x2_q));
        end
    end

    assign in_ready_o  = in_ready_q;
    assign x1_o        = x1_q;
    assign x2_o        = x2_q;
    assign cl_n_o      = cl_n_q;
    assign pr_n_o      = pr_n_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign err_count_o = err_count_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Bench for ff_excitation_driver: five drivers (SR, JK, D, T with CW=8 and
// SR with CW=2) share one stimulus stream, each steering its own flip-flop
// model; a session-level reference model predicts every output each cycle.
module tb_ff_excitation_driver;

    localparam int NI = 5;

    function automatic int ft_of(input int i);
        return (i == 4) ? 0 : i;
    endfunction

    function automatic int cw_of(input int i);
        return (i == 4) ? 2 : 8;
    endfunction

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic reset = 1'b1, start = 1'b0, init_val = 1'b0, stop = 1'b0;
    logic in_valid = 1'b0, in_data = 1'b0;
    logic [NI-1:0] force_q = '0;
    logic [NI-1:0] rdy_w, x1_w, x2_w, cln_w, prn_w, busy_w, err_w, done_w, q_w;
    logic [7:0]    cnt_w [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int FTG = (g == 4) ? 0 : g;
        localparam int CWG = (g == 4) ? 2 : 8;
        logic [CWG-1:0] cnt_l;
        logic           ffq;

        ff_excitation_driver #(.FF_TYPE(FTG), .CW(CWG)) u_dut (
            .ck_i        (ck),
            .reset_i     (reset),
            .start_i     (start),
            .init_val_i  (init_val),
            .stop_i      (stop),
            .in_valid_i  (in_valid),
            .in_data_i   (in_data),
            .in_ready_o  (rdy_w[g]),
            .x1_o        (x1_w[g]),
            .x2_o        (x2_w[g]),
            .cl_n_o      (cln_w[g]),
            .pr_n_o      (prn_w[g]),
            .q_i         (q_w[g]),
            .busy_o      (busy_w[g]),
            .err_o       (err_w[g]),
            .err_count_o (cnt_l),
            .done_o      (done_w[g])
        );

        assign cnt_w[g] = 8'(cnt_l);
        assign q_w[g]   = force_q[g] ? 1'b0 : ffq;

        // Flip-flop under test, clocked by the shared clock.
        always @(posedge ck or negedge cln_w[g] or negedge prn_w[g]) begin
            if (!cln_w[g])      ffq <= 1'b0;
            else if (!prn_w[g]) ffq <= 1'b1;
            else begin
                case (FTG)
                    0: begin
                        if (x1_w[g] && !x2_w[g])      ffq <= 1'b1;
                        else if (!x1_w[g] && x2_w[g]) ffq <= 1'b0;
                    end
                    1:       ffq <= (x1_w[g] & ~ffq) | (~x2_w[g] & ffq);
                    2:       ffq <= x1_w[g];
                    default: ffq <= ffq ^ x1_w[g];
                endcase
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [1:0] m_excite(input int ft, input logic cur, input logic nxt);
        if (ft == 2) return {nxt, 1'b0};
        if (ft == 3) return {cur ^ nxt, 1'b0};
        if (cur == nxt) return 2'b00;
        return nxt ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] m_hold(input int ft, input logic cur);
        return (ft == 2) ? {cur, 1'b0} : 2'b00;
    endfunction

    bit          m_active, m_rdy, m_cl = 1'b1, m_pr = 1'b1, m_done, m_qchk, m_qexp;
    int          m_t, m_ts, cyc;
    bit [NI-1:0] m_cur, m_x1, m_x2, m_err, m_qseen, m_forced;
    int          m_cnt [NI];
    int          pend_due [$];
    bit          pend_bit [$];

    always @(posedge ck) begin
        bit acc;
        cyc++;
        m_qchk = 1'b0;
        m_done = 1'b0;
        m_err  = '0;
        if (reset) begin
            m_active = 1'b0; m_rdy = 1'b0; m_cl = 1'b1; m_pr = 1'b1;
            m_cur = '0; m_x1 = '0; m_x2 = '0;
            for (int i = 0; i < NI; i++) m_cnt[i] = 0;
            pend_due.delete();
            pend_bit.delete();
        end else begin
            if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                m_qchk = 1'b1;
                m_qexp = pend_bit[0];
                void'(pend_due.pop_front());
                void'(pend_bit.pop_front());
                for (int i = 0; i < NI; i++) begin
                    m_qseen[i]  = q_w[i];
                    m_forced[i] = force_q[i];
                    if (q_w[i] != m_qexp) begin
                        m_err[i] = 1'b1;
                        if (m_cnt[i] < (1 << cw_of(i)) - 1) m_cnt[i]++;
                    end
                end
            end
            acc  = m_rdy && in_valid;
            m_cl = 1'b1;
            m_pr = 1'b1;
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1; m_t = 0; m_ts = -1;
                    m_cl = init_val; m_pr = !init_val;
                    for (int i = 0; i < NI; i++) begin
                        m_cur[i] = init_val;
                        m_cnt[i] = 0;
                    end
                end
            end else begin
                m_t++;
                if (m_rdy && stop) m_ts = m_t;
                if (m_ts >= 0 && m_t == m_ts + 2) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
            for (int i = 0; i < NI; i++) begin
                if (acc) begin
                    {m_x1[i], m_x2[i]} = m_excite(ft_of(i), m_cur[i], in_data);
                    m_cur[i] = in_data;
                end else begin
                    {m_x1[i], m_x2[i]} = m_hold(ft_of(i), m_cur[i]);
                end
            end
            if (acc) begin
                pend_due.push_back(cyc + 2);
                pend_bit.push_back(in_data);
            end
            m_rdy = m_active && m_t >= 2 && m_ts < 0;
        end
    end

    // ---------------- compare ----------------
    int total = 0, bad = 0;
    int lit_id = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input int i, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s[%0d] at cycle %0d: got %0d, want %0d", nm, i, cyc, act, exp);
        end
    endtask

    always @(negedge ck) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                check("in_ready", i, int'(rdy_w[i]), int'(m_rdy));
                check("busy", i, int'(busy_w[i]), int'(m_active));
                check("done", i, int'(done_w[i]), int'(m_done));
                check("cl_n", i, int'(cln_w[i]), int'(m_cl));
                check("pr_n", i, int'(prn_w[i]), int'(m_pr));
                check("x1", i, int'(x1_w[i]), int'(m_x1[i]));
                check("x2", i, int'(x2_w[i]), int'(m_x2[i]));
                check("err", i, int'(err_w[i]), int'(m_err[i]));
                check("err_count", i, int'(cnt_w[i]), m_cnt[i]);
                if (m_qchk && !m_forced[i]) check("ff_q", i, int'(m_qseen[i]), int'(m_qexp));
            end
            case (lit_id)
                1: for (int i = 0; i < NI; i++) begin
                       check("rst_cnt", i, int'(cnt_w[i]), 0);
                       check("rst_cl", i, int'(cln_w[i]), 1);
                       check("rst_pr", i, int'(prn_w[i]), 1);
                       check("rst_busy", i, int'(busy_w[i]), 0);
                   end
                2: check("d_cnt", 2, int'(cnt_w[2]), 0);
                3: begin
                       check("sr_cnt3", 0, int'(cnt_w[0]), 3);
                       check("sr_cnt3", 4, int'(cnt_w[4]), 3);
                       check("jk_cnt3", 1, int'(cnt_w[1]), 0);
                   end
                4: begin
                       check("sr_cnt5", 0, int'(cnt_w[0]), 5);
                       check("sr_sat", 4, int'(cnt_w[4]), 3);
                   end
                5: begin
                       check("abort_cnt", 0, int'(cnt_w[0]), 0);
                       check("abort_rdy", 0, int'(rdy_w[0]), 0);
                       check("abort_busy", 3, int'(busy_w[3]), 0);
                       check("abort_done", 2, int'(done_w[2]), 0);
                   end
                6: check("same_edge_done", 1, int'(done_w[1]), 1);
                default: ;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge ck);
        #2;
    endtask

    task automatic begin_session(input logic iv);
        start = 1'b1; init_val = iv;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic send(input logic b, input int gap);
        in_valid = 1'b1; in_data = b;
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic end_session();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();
    endtask

    task automatic literal(input int id);
        lit_id = id;
        tick();
        lit_id = 0;
    endtask

    initial begin
        logic [4:0] bits;
        int n;
        bit stopped;

        tick();
        chk_en = 1'b1;
        literal(1);
        reset = 1'b0;

        // stop in IDLE is ignored
        stop = 1'b1; tick(); stop = 1'b0; tick();

        // D-style stream, back to back, with a start pulse while busy
        begin_session(1'b0);
        bits = 5'b01011;
        for (int k = 0; k < 5; k++) begin
            start = (k == 2); init_val = 1'b1;
            send(bits[k], 0);
        end
        start = 1'b0;
        end_session();
        literal(2);

        // JK-style stream from preset
        begin_session(1'b1);
        send(1'b1, 0); send(1'b0, 0); send(1'b0, 0); send(1'b1, 0);
        end_session();

        // T-style stream with gaps
        begin_session(1'b0);
        send(1'b1, 2); send(1'b0, 2); send(1'b1, 2); send(1'b1, 2);
        end_session();

        // SR instances see q stuck at 0
        force_q = 5'b10001;
        begin_session(1'b0);
        repeat (3) send(1'b1, 0);
        end_session();
        literal(3);
        begin_session(1'b0);
        repeat (5) send(1'b1, 0);
        end_session();
        literal(4);

        // reset with two bits in flight after one counted mismatch
        force_q = 5'b00001;
        begin_session(1'b0);
        send(1'b1, 2);
        send(1'b1, 0);
        send(1'b1, 0);
        reset = 1'b1; tick(); reset = 1'b0;
        literal(5);
        force_q = '0;
        tick();

        // stop on the same edge as an accept
        begin_session(1'b0);
        in_valid = 1'b1; in_data = 1'b1; stop = 1'b1;
        tick();
        in_valid = 1'b0; stop = 1'b0;
        tick(); tick();
        literal(6);
        tick();

        // randomized sessions
        repeat (40) begin
            force_q = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
            stop = 1'($urandom_range(0, 1)); tick(); stop = 1'b0;
            begin_session(1'($urandom_range(0, 1)));
            n = $urandom_range(1, 12);
            stopped = 1'b0;
            for (int k = 0; k < n; k++) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 1'($urandom_range(0, 1));
                start    = ($urandom_range(0, 7) == 0);
                init_val = 1'($urandom_range(0, 1));
                stop     = (k == n - 1) && ($urandom_range(0, 1) == 1);
                stopped  = stop;
                tick();
            end
            in_valid = 1'b0; start = 1'b0; stop = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b1; tick(); reset = 1'b0; tick();
            end else begin
                if (!stopped) begin
                    stop = 1'b1; tick(); stop = 1'b0;
                end
                repeat (3) tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
